ones_mod_counter: RTL and testbench
===================================

Name: ones_mod_counter

Overview:
- Parametrised successor to the 2-input "ones count divisible by 4" FSM.
- Each enabled cycle, the block accumulates the number of asserted bits on an N_IN-bit input bus, modulo a modulus that is loadable at run time.
- z flags that the running total since the last reset/clear/load is a multiple of the modulus.
- Adds a counting mode, a wrap pulse and a saturating wrap counter.
- Sits in the FSM lab library as a reusable divisibility detector for multi-bit event streams.

Parameters:
- N_IN, 2, width of input bus; 1..16.
- CNT_W, 3, width of residue and modulus registers; modulus range 1..2**CNT_W-1.
- DEFAULT_MOD, 4, modulus after reset; 1..2**CNT_W-1.
- WRAP_W, 8, width of saturating wrap counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  sample in_bits this cycle
- clr  in  1  synchronous clear of residue and wrap count
- mode  in  1  0 = add popcount(in_bits); 1 = add 1 if any bit of in_bits is set
- in_bits  in  N_IN  input event bits
- mod_load  in  1  load new modulus from mod_val
- mod_val  in  CNT_W  new modulus value
- z  out  1  residue == 0
- residue  out  CNT_W  current residue
- wrap  out  1  registered one-cycle pulse: last update reached or crossed a multiple
- wrap_cnt  out  WRAP_W  number of wraps since reset/clr, saturating
- mod_err  out  1  registered one-cycle pulse: mod_load rejected

Behaviour:
- Registers: r (residue), m (modulus), wrap, wrap_cnt, mod_err.
- Reset values: r = 0, m = DEFAULT_MOD, wrap = 0, wrap_cnt = 0, mod_err = 0. Therefore z = 1 out of reset.
- z is combinational from r (z = (r == 0)), so it is valid in the same cycle as r. residue = r.
- Increment:
  - inc = popcount(in_bits) when mode = 0.
  - inc = |in_bits when mode = 1.
  - inc = 0 when en = 0.
- sum = r + inc, computed at width CNT_W+5 with no overflow.
- Next residue = sum mod m, as a true modulo. inc may exceed m (e.g. N_IN = 8, m = 3), so a single conditional subtract is not sufficient. Implement it as a bounded combinational reduction.
- wrap_next = en & (sum >= m). wrap is high for exactly one cycle after the qualifying edge. inc = 0 never wraps.
- wrap_cnt increments by 1 on each wrap_next and holds at 2**WRAP_W-1. It counts one per update, even when sum >= 2m.
- Priority per clock edge: rst > clr > mod_load > en.
  - clr: r = 0, wrap_cnt = 0, wrap = 0. m unchanged. A simultaneous mod_load is ignored and gives no mod_err.
  - mod_load with mod_val != 0: m = mod_val, r = 0, wrap = 0. wrap_cnt unchanged. en is ignored that cycle.
  - mod_load with mod_val == 0: m and r unchanged; mod_err = 1 for one cycle. The en update still proceeds the same cycle.
  - en only: normal update described above.
  - none asserted: all registers hold, wrap = 0, mod_err = 0.
- m = 1: r is always 0, z is always 1, and every update with inc > 0 wraps.
- Reset mid-operation returns to reset values immediately (asynchronous), independent of clk.
- Latency: an input sampled at edge k is reflected in residue, z and wrap after edge k.
- Legacy equivalence: N_IN = 2, m = 4, mode = 0, en = 1 reproduces the 2-input divisible-by-4 FSM exactly.

Decomposition:
- Package ones_mod_pkg:
  - MODE_POPCNT = 1'b0, MODE_ANY = 1'b1.
  - Helper function clog2 for sizing the sum.
  - Parameter legality checks, implemented as elaboration-time asserts.
- Sub-module popcnt_n: parametrised combinational popcount over N_IN bits. Output width is clog2(N_IN+1).
- Modulo reduction, priority control and counters stay in ones_mod_counter.

Test Plan:
- Reset then idle: rst pulse, en = 0 for 5 cycles -> z = 1, residue = 0, wrap = 0, wrap_cnt = 0 throughout.
- Legacy sequence, N_IN = 2, m = 4, mode 0: in_bits 01, 11, 00, 10 -> residue 1, 3, 3, 0. z = 1 after the 4th edge. wrap pulses once, after the 4th edge. wrap_cnt = 1.
- Large increment, N_IN = 8, mod_load with mod_val = 3, then in_bits = 0xFF with en -> residue = 8 mod 3 = 2, wrap = 1, wrap_cnt = 1. Next in_bits = 0x01 -> residue 0, z = 1, wrap = 1, wrap_cnt = 2.
- Mode 1: mode = 1, m = 4, in_bits 0x3, 0x0, 0x2, 0x1, 0x3 -> residue 1, 1, 2, 3, 0. z = 1 after the 5th edge.
- Load rejection and priority:
  - mod_load with mod_val = 0 while en = 1 and in_bits = 01 -> mod_err = 1 for one cycle, m unchanged, residue advances by 1.
  - clr and mod_load together -> residue 0, wrap_cnt 0, m unchanged, no mod_err.
- Saturation and async reset:
  - WRAP_W = 2, force 5 wraps -> wrap_cnt holds at 3.
  - Assert rst between clock edges mid-count -> residue 0, z = 1, m = DEFAULT_MOD immediately.

Source files
------------

// File: rtl/ones_mod_pkg.sv
// rtl/ones_mod_pkg.sv - shared constants and sizing helpers for ones_mod_counter
package ones_mod_pkg;

    // Increment selection for the mode input
    localparam logic MODE_POPCNT = 1'b0;   // add popcount(in_bits)
    localparam logic MODE_ANY    = 1'b1;   // add 1 if any bit of in_bits is set

    // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(9) = 4
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // Parameter legality, evaluated at elaboration by the counter
    function automatic bit params_legal(input int n_in, input int cnt_w,
                                        input int default_mod, input int wrap_w);
        bit ok;
        ok = 1'b1;
        if (n_in < 1 || n_in > 16)                          ok = 1'b0;
        if (cnt_w < 1 || cnt_w > 26)                        ok = 1'b0;
        if (default_mod < 1 || default_mod > (1 << cnt_w) - 1) ok = 1'b0;
        if (wrap_w < 1)                                     ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/popcnt_n.sv
// rtl/popcnt_n.sv - combinational population count over an N_IN-bit bus
//
// Ports:
//   in_bits  in   N_IN   bits to count
//   count    out  OUT_W  number of set bits in in_bits (0..N_IN)
module popcnt_n
    import ones_mod_pkg::*;
#(
    parameter int N_IN  = 2,
    parameter int OUT_W = clog2(N_IN + 1)
) (
    input  logic [N_IN-1:0]  in_bits,
    output logic [OUT_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < N_IN; i++) begin
            count = count + OUT_W'(in_bits[i]);
        end
    end

endmodule

// File: rtl/ones_mod_counter.sv
// rtl/ones_mod_counter.sv - running ones count modulo a loadable modulus
//
// Ports:
//   clk       in   1       clock, rising edge
//   rst       in   1       asynchronous active-high reset
//   en        in   1       sample in_bits this cycle
//   clr       in   1       synchronous clear of residue and wrap count
//   mode      in   1       MODE_POPCNT: add popcount, MODE_ANY: add |in_bits
//   in_bits   in   N_IN    input event bits
//   mod_load  in   1       load new modulus from mod_val
//   mod_val   in   CNT_W   new modulus value (0 is rejected)
//   z         out  1       residue == 0
//   residue   out  CNT_W   current residue
//   wrap      out  1       one-cycle pulse: last update reached/crossed a multiple
//   wrap_cnt  out  WRAP_W  saturating count of wraps since reset/clr
//   mod_err   out  1       one-cycle pulse: mod_load with mod_val == 0
module ones_mod_counter
    import ones_mod_pkg::*;
#(
    parameter int N_IN        = 2,
    parameter int CNT_W       = 3,
    parameter int DEFAULT_MOD = 4,
    parameter int WRAP_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic              mode,
    input  logic [N_IN-1:0]   in_bits,
    input  logic              mod_load,
    input  logic [CNT_W-1:0]  mod_val,
    output logic              z,
    output logic [CNT_W-1:0]  residue,
    output logic              wrap,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              mod_err
);

    localparam int PC_W  = clog2(N_IN + 1);
    localparam int SUM_W = CNT_W + 5;

    if (!params_legal(N_IN, CNT_W, DEFAULT_MOD, WRAP_W)) begin : g_param_check
        $error("ones_mod_counter: illegal parameter combination");
    end

    logic [CNT_W-1:0]  r_q;
    logic [CNT_W-1:0]  m_q;
    logic              wrap_q;
    logic [WRAP_W-1:0] wcnt_q;
    logic              err_q;

    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   inc;
    logic [SUM_W-1:0]  sum;
    logic [SUM_W-1:0]  red;
    logic [CNT_W-1:0]  r_next;
    logic              wrap_hit;
    logic              load_ok;

    popcnt_n #(
        .N_IN  (N_IN),
        .OUT_W (PC_W)
    ) u_popcnt (
        .in_bits (in_bits),
        .count   (pc)
    );

    always_comb begin
        inc = '0;
        if (en) begin
            inc = (mode == MODE_ANY) ? PC_W'(|in_bits) : pc;
        end
    end

    assign sum = SUM_W'(r_q) + SUM_W'(inc);

    // r < m always holds, so sum < m + inc and sum / m <= inc <= N_IN:
    // N_IN conditional subtracts always reach the true remainder, even for m = 1.
    always_comb begin
        red = sum;
        for (int i = 0; i < N_IN; i++) begin
            if (red >= SUM_W'(m_q)) begin
                red = red - SUM_W'(m_q);
            end
        end
    end

    assign r_next   = red[CNT_W-1:0];
    assign wrap_hit = en && (sum >= SUM_W'(m_q));
    assign load_ok  = mod_load && (mod_val != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= '0;
            m_q    <= CNT_W'(DEFAULT_MOD);
            wrap_q <= 1'b0;
            wcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
            if (clr) begin
                // A simultaneous mod_load is dropped silently
                r_q    <= '0;
                wcnt_q <= '0;
            end else if (load_ok) begin
                // New modulus restarts the running total; en is ignored
                m_q <= mod_val;
                r_q <= '0;
            end else begin
                // A rejected load (mod_val == 0) still lets the update through
                err_q <= mod_load;
                if (en) begin
                    r_q    <= r_next;
                    wrap_q <= wrap_hit;
                    if (wrap_hit && (wcnt_q != '1)) begin
                        wcnt_q <= wcnt_q + WRAP_W'(1);
                    end
                end
            end
        end
    end

    assign z        = (r_q == '0);
    assign residue  = r_q;
    assign wrap     = wrap_q;
    assign wrap_cnt = wcnt_q;
    assign mod_err  = err_q;

endmodule

// File: tb/tb_ones_mod_counter.sv
// tb/tb_ones_mod_counter.sv - self-checking bench for ones_mod_counter
module tb_ones_mod_counter;

    localparam int N_IN        = 8;
    localparam int CNT_W       = 3;
    localparam int DEFAULT_MOD = 4;
    localparam int WRAP_W      = 2;
    localparam int WRAP_MAX    = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              clr;
    logic              mode;
    logic [N_IN-1:0]   in_bits;
    logic              mod_load;
    logic [CNT_W-1:0]  mod_val;
    logic              z;
    logic [CNT_W-1:0]  residue;
    logic              wrap;
    logic [WRAP_W-1:0] wrap_cnt;
    logic              mod_err;

    int total_cnt = 0;
    int bad_cnt   = 0;

    // Reference: total events since last reset/clr/load, and whole multiples passed
    int m_mod;
    int m_total;
    int m_wraps;
    bit m_wrap;
    bit m_err;

    ones_mod_counter #(
        .N_IN        (N_IN),
        .CNT_W       (CNT_W),
        .DEFAULT_MOD (DEFAULT_MOD),
        .WRAP_W      (WRAP_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr      (clr),
        .mode     (mode),
        .in_bits  (in_bits),
        .mod_load (mod_load),
        .mod_val  (mod_val),
        .z        (z),
        .residue  (residue),
        .wrap     (wrap),
        .wrap_cnt (wrap_cnt),
        .mod_err  (mod_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) else begin
            bad_cnt++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_residue"},  32'(residue),  32'(m_total % m_mod));
        check({tag, "_z"},        32'(z),        32'((m_total % m_mod) == 0));
        check({tag, "_wrap"},     32'(wrap),     32'(m_wrap));
        check({tag, "_wrap_cnt"}, 32'(wrap_cnt), 32'(m_wraps));
        check({tag, "_mod_err"},  32'(mod_err),  32'(m_err));
    endtask

    task automatic model_reset();
        m_mod   = DEFAULT_MOD;
        m_total = 0;
        m_wraps = 0;
        m_wrap  = 0;
        m_err   = 0;
    endtask

    task automatic model_edge(input bit e, input bit c, input bit md,
                              input logic [N_IN-1:0] b, input bit ld, input int v);
        int inc;
        if (c) begin
            m_total = 0;
            m_wraps = 0;
            m_wrap  = 0;
            m_err   = 0;
        end else if (ld && v != 0) begin
            m_mod   = v;
            m_total = 0;
            m_wrap  = 0;
            m_err   = 0;
        end else begin
            m_err = ld;
            inc   = !e ? 0 : (md ? int'(b != 0) : $countones(b));
            // A wrap means the running total crossed into a new multiple of m
            m_wrap  = ((m_total + inc) / m_mod) != (m_total / m_mod);
            m_total = m_total + inc;
            if (m_wrap && m_wraps < WRAP_MAX) m_wraps++;
        end
    endtask

    task automatic drive(input string tag, input bit e, input bit c, input bit md,
                         input logic [N_IN-1:0] b, input bit ld, input int v);
        en       = e;
        clr      = c;
        mode     = md;
        in_bits  = b;
        mod_load = ld;
        mod_val  = CNT_W'(v);
        @(posedge clk);
        model_edge(e, c, md, b, ld, v);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [N_IN-1:0] legacy_bits [4];
        logic [N_IN-1:0] any_bits    [5];
        legacy_bits = '{8'h01, 8'h03, 8'h00, 8'h02};
        any_bits    = '{8'h03, 8'h00, 8'h02, 8'h01, 8'h03};

        rst = 1'b1; en = 0; clr = 0; mode = 0; in_bits = '0; mod_load = 0; mod_val = '0;
        model_reset();
        #12;
        rst = 1'b0;
        #1;
        check_all("reset");

        for (int i = 0; i < 5; i++) drive("idle", 0, 0, 0, 8'hFF, 0, 0);

        // Legacy divisible-by-4 behaviour on two bits
        for (int i = 0; i < 4; i++) drive("legacy", 1, 0, 0, legacy_bits[i], 0, 0);
        check("legacy_final_residue", 32'(residue), 0);
        check("legacy_final_wcnt", 32'(wrap_cnt), 1);

        // Increment larger than the modulus
        drive("clr0", 0, 1, 0, 8'h00, 0, 0);
        drive("load3", 1, 0, 0, 8'hFF, 1, 3);
        drive("big_ff", 1, 0, 0, 8'hFF, 0, 0);
        check("big_ff_residue", 32'(residue), 2);
        drive("big_01", 1, 0, 0, 8'h01, 0, 0);
        check("big_01_wcnt", 32'(wrap_cnt), 2);

        // Any-bit counting mode
        drive("clr1", 0, 1, 0, 8'h00, 0, 0);
        drive("load4", 0, 0, 0, 8'h00, 1, 4);
        for (int i = 0; i < 5; i++) drive("any", 1, 0, 1, any_bits[i], 0, 0);
        check("any_final_z", 32'(z), 1);

        // Rejected load still lets the update through
        drive("rej", 1, 0, 0, 8'h01, 1, 0);
        check("rej_err", 32'(mod_err), 1);
        drive("rej_after", 0, 0, 0, 8'h00, 0, 0);
        drive("rej_m4", 1, 0, 0, 8'h07, 0, 0);

        // clr beats mod_load
        drive("clr_ld", 1, 1, 0, 8'h0F, 1, 5);
        drive("clr_ld_m4", 1, 0, 0, 8'h1F, 0, 0);

        // m = 1 with saturation of the 2-bit wrap counter
        drive("load1", 0, 0, 0, 8'h00, 1, 1);
        for (int i = 0; i < 5; i++) drive("sat", 1, 0, 0, 8'h0F, 0, 0);
        check("sat_wcnt", 32'(wrap_cnt), 3);

        // Asynchronous reset between edges, then confirm DEFAULT_MOD is back
        drive("load7", 0, 0, 0, 8'h00, 1, 7);
        drive("pre_rst", 1, 0, 0, 8'h07, 0, 0);
        en = 0; mod_load = 0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        #2 rst = 1'b0;
        drive("post_rst", 1, 0, 0, 8'h1F, 0, 0);
        check("post_rst_residue", 32'(residue), 1);

        // Randomised traffic against the reference
        for (int i = 0; i < 400; i++) begin
            drive("rand",
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 24) == 0,
                  $urandom_range(0, 1) == 1,
                  N_IN'($urandom),
                  $urandom_range(0, 11) == 0,
                  int'($urandom_range(0, 7)));
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
